switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1250000 (10 ms at 125 MHz), meaning the number of consecutive stable clk cycles required to accept a value; legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  system clock, 125 MHz, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port switch  input  2  raw board switches, asynchronous to clk, bouncing.
REQ-005 SHALL have port mode  output  2  debounced switch value, fed to the LED pattern stage as its mode select.
REQ-006 SHALL have port mode_valid  output  1  high once the first debounced value is accepted after reset.
REQ-007 SHALL have port mode_change  output  1  one-cycle pulse in the cycle mode takes a new, different value.
REQ-008 SHALL have port settling  output  1  high while a candidate value differing from mode is being timed.

Function
REQ-009 SHALL pass each switch bit through a 2-flop synchronizer (sync) before any other use.
REQ-010 SHALL debounce the 2-bit sync vector as one word; mode SHALL never show a combination that was not held stable for DEBOUNCE_CYCLES.
REQ-011 SHALL implement FSM states STARTUP, STABLE, SETTLING, with a candidate register cand[1:0] and counter cnt of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-012 STARTUP: cnt increments while sync == cand; on sync != cand, load cand = sync and cnt = 0.
REQ-013 STARTUP: when cnt == DEBOUNCE_CYCLES-1 and sync == cand, SHALL load mode = cand, set mode_valid = 1, go to STABLE, no mode_change pulse.
REQ-014 STABLE: on sync != mode, SHALL load cand = sync, cnt = 0, go to SETTLING; otherwise hold.
REQ-015 SETTLING: on sync == cand, cnt increments; on sync == mode, SHALL return to STABLE with mode unchanged and no pulse (glitch rejected).
REQ-016 SETTLING: on sync differing from both cand and mode, SHALL reload cand = sync, cnt = 0, stay in SETTLING.
REQ-017 SETTLING: when cnt == DEBOUNCE_CYCLES-1 and sync == cand, SHALL load mode = cand, pulse mode_change for exactly one cycle, go to STABLE.
REQ-018 Latency: a clean raw change sampled at rising edge k SHALL appear on mode, with mode_change high, in the cycle after edge k+DEBOUNCE_CYCLES+3.
REQ-019 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-020 settling SHALL equal (state == SETTLING); it SHALL be low in STARTUP and STABLE.
REQ-021 mode_change and settling SHALL be registered outputs; mode_change SHALL never assert while mode_valid is low.
REQ-022 Consecutive accepted changes SHALL be separated by at least DEBOUNCE_CYCLES+1 cycles.

Reset
REQ-023 While rst_n is low: sync flops = 00, cand = 00, cnt = 0, state = STARTUP, mode = 00, mode_valid = 0, mode_change = 0, settling = 0.
REQ-024 Reset asserted mid-SETTLING SHALL discard the candidate immediately; after release, the FSM SHALL restart from STARTUP and mode_valid SHALL re-qualify per REQ-013.
REQ-025 Deassertion of rst_n is externally synchronized to clk; the block adds no reset synchronizer.

Verification (DEBOUNCE_CYCLES = 8)
REQ-026 Reset release with switch = 10 held -> mode_valid rises with mode = 10 after 8 stable sync cycles; mode_change stays 0 throughout.
REQ-027 From stable mode 00, step switch to 01 and hold -> settling high for 8 cycles, then mode = 01 and mode_change high for 1 cycle, 11 cycles after the sampling edge.
REQ-028 From mode 00, toggle switch 00/11 every 3 cycles for 60 cycles, then hold 00 -> mode stays 00, mode_change never asserts, settling finally returns low.
REQ-029 From mode 00, drive 01 for 5 cycles then 11 held -> cand reloads to 11 and mode becomes 11 (never 01) with a single mode_change pulse.
REQ-030 Assert rst_n low at cnt = 5 in SETTLING toward 11 -> all outputs zero immediately; after release with 11 held, mode_valid rises with mode = 11 and no pulse.
REQ-031 Hold switch = 11 for 7 cycles, then return to the previous mode 00 -> no mode change (one cycle short of the window), settling returns low.

Source files
------------

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : Two-bit board switch debouncer. Both raw switch bits are
//               synchronised, then debounced together as one word. A value
//               is accepted only after DEBOUNCE_CYCLES consecutive stable
//               cycles. The accepted word drives the LED pattern mode select.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] switch,
    output logic [1:0] mode,
    output logic       mode_valid,
    output logic       mode_change,
    output logic       settling
);

    localparam int                 CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_STARTUP  = 2'd0;
    localparam logic [1:0] c_STABLE   = 2'd1;
    localparam logic [1:0] c_SETTLING = 2'd2;

    logic [1:0]       r_meta;
    logic [1:0]       r_sync;

    logic [1:0]       r_state;
    logic [1:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_acc;
    logic             r_acc_valid;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_cand_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_acc_nxt;
    logic             w_acc_valid_nxt;

    logic             w_mode_change_d;
    logic             w_settling_d;

    // Two-flop synchroniser on each raw switch bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= switch;
            r_sync <= r_meta;
        end
    end

    // FSM state and debounce datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_STARTUP;
            r_cand      <= 2'b00;
            r_cnt       <= '0;
            r_acc       <= 2'b00;
            r_acc_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_acc_valid <= w_acc_valid_nxt;
        end
    end

    // Next-state logic: time the candidate word, accept it after a full
    // stable window, reject glitches that fall back to the accepted word.
    always_comb begin
        w_state_nxt     = r_state;
        w_cand_nxt      = r_cand;
        w_cnt_nxt       = r_cnt;
        w_acc_nxt       = r_acc;
        w_acc_valid_nxt = r_acc_valid;
        case (r_state)
            c_STARTUP: begin
                if (r_sync != r_cand) begin
                    w_cand_nxt = r_sync;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_acc_nxt       = r_cand;
                    w_acc_valid_nxt = 1'b1;
                    w_state_nxt     = c_STABLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            c_STABLE: begin
                if (r_sync != r_acc) begin
                    w_cand_nxt  = r_sync;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_SETTLING;
                end
            end
            c_SETTLING: begin
                if (r_sync == r_cand) begin
                    if (r_cnt == c_CNT_MAX) begin
                        w_acc_nxt   = r_cand;
                        w_state_nxt = c_STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else if (r_sync == r_acc) begin
                    // Glitch: input went back to the accepted word.
                    w_state_nxt = c_STABLE;
                end else begin
                    w_cand_nxt = r_sync;
                    w_cnt_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = c_STARTUP;
                w_cand_nxt  = 2'b00;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: a change pulse only for a new word once already valid,
    // so the first acceptance after reset never pulses.
    always_comb begin
        w_mode_change_d = r_acc_valid && mode_valid && (r_acc != mode);
        w_settling_d    = (r_state == c_SETTLING);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode        <= 2'b00;
            mode_valid  <= 1'b0;
            mode_change <= 1'b0;
            settling    <= 1'b0;
        end else begin
            mode        <= r_acc;
            mode_valid  <= r_acc_valid;
            mode_change <= w_mode_change_d;
            settling    <= w_settling_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debounce
// Description : Scoreboard bench for switch_debounce with DEBOUNCE_CYCLES = 8.
//               Stimulus pushes expected output events (value, kind, cycle);
//               a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    localparam int N   = 8;
    localparam int LAT = N + 4;  // drive at negedge c -> output at negedge c+N+4

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] switch;
    logic [1:0] mode;
    logic       mode_valid;
    logic       mode_change;
    logic       settling;

    typedef struct {
        bit         is_chg;
        logic [1:0] md;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    logic prev_v = 1'b0;

    switch_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .switch      (switch),
        .mode        (mode),
        .mode_valid  (mode_valid),
        .mode_change (mode_change),
        .settling    (settling)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_chg, input logic [1:0] md);
        exp_t e;
        e.is_chg = is_chg;
        e.md     = md;
        e.cyc    = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every valid rise or change pulse is one scoreboard event.
    always @(negedge clk) begin
        exp_t e;
        if (mode_change)
            chk("change_needs_valid", int'(mode_valid), 1);
        if ((mode_valid && !prev_v) || mode_change) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got mode=%0d change=%0d at cycle %0d, required no event",
                         mode, mode_change, cyc);
            end else begin
                e = q.pop_front();
                chk("event_kind", int'(mode_change), int'(e.is_chg));
                chk("event_mode", int'(mode), int'(e.md));
                chk("event_cycle", cyc, e.cyc);
            end
        end
        prev_v <= mode_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        switch = 2'b10;
        wait_n(3);
        chk("rst_mode", int'(mode), 0);
        chk("rst_valid", int'(mode_valid), 0);
        chk("rst_change", int'(mode_change), 0);
        chk("rst_settling", int'(settling), 0);

        // Startup qualification with 10 held: valid rise, no pulse.
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 2'b10);
        wait_n(20);
        chk("startup_settling", int'(settling), 0);

        // Move to mode 00.
        @(negedge clk);
        switch = 2'b00;
        push(1'b1, 2'b00);
        wait_n(15);

        // Clean step 00 -> 01: settling window of exactly N cycles.
        @(negedge clk);
        switch = 2'b01;
        push(1'b1, 2'b01);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("settle_window", int'(settling), int'(i >= 4 && i <= 11));
        end
        wait_n(5);
        @(negedge clk);
        switch = 2'b00;
        push(1'b1, 2'b00);
        wait_n(15);

        // Bouncing 00/11 every 3 cycles for 60 cycles: no change.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            switch = (i % 2 == 0) ? 2'b11 : 2'b00;
            wait_n(2);
        end
        @(negedge clk);
        switch = 2'b00;
        wait_n(20);
        chk("bounce_settling", int'(settling), 0);
        chk("bounce_mode", int'(mode), 0);

        // 01 for 5 cycles then 11 held: candidate reloads, mode goes to 11.
        @(negedge clk);
        switch = 2'b01;
        wait_n(4);
        @(negedge clk);
        switch = 2'b11;
        push(1'b1, 2'b11);
        wait_n(15);
        chk("reload_mode", int'(mode), 3);
        @(negedge clk);
        switch = 2'b00;
        push(1'b1, 2'b00);
        wait_n(15);

        // 11 for 7 cycles then back to 00: one short, rejected.
        @(negedge clk);
        switch = 2'b11;
        wait_n(6);
        chk("short_settling_mid", int'(settling), 1);
        @(negedge clk);
        switch = 2'b00;
        wait_n(15);
        chk("short_settling_end", int'(settling), 0);
        chk("short_mode", int'(mode), 0);

        // Reset mid-settling toward 11 at cnt = 5.
        @(negedge clk);
        switch = 2'b11;
        wait_n(8);
        chk("pre_rst_settling", int'(settling), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_valid", int'(mode_valid), 0);
        chk("midrst_change", int'(mode_change), 0);
        chk("midrst_settling", int'(settling), 0);
        wait_n(4);
        rst_n = 1'b1;
        push(1'b0, 2'b11);
        wait_n(20);
        chk("requal_mode", int'(mode), 3);

        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
